// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester arbiter in front of a shared 4-bit register.
// A requester holds req high with an opcode and operand until it sees its
// done pulse. The arbiter grants one requester, replays the latched
// operation as strobes onto the shared register, then pulses done.
// All outputs come straight from flops.
//
// Build option:
//   REG_ARB_FIXED_PRIO_EN  defined   -> simultaneous requests always grant A
//   REG_ARB_FIXED_PRIO_EN  undefined -> round-robin between A and B
module reg_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [2:0] op_a,
    input  logic [2:0] op_b,
    input  logic [3:0] data_a,
    input  logic [3:0] data_b,
    output logic       done_a,
    output logic       done_b,
    output logic       reg_cl,
    output logic       reg_ld,
    output logic       reg_inc,
    output logic       reg_dec,
    output logic       reg_sr,
    output logic       reg_sl,
    output logic       reg_ir,
    output logic       reg_il,
    output logic [3:0] reg_in,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcode values. CLR..SHL occupy 1..6, so strobe index = opcode - 1.
    localparam logic [2:0] OP_LD  = 3'd2;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;

    localparam int NUM_STRB = 6;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [3:0]          data_q, data_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                owner_q, owner_d;

    // Registered output images, computed from next-state values.
    logic [NUM_STRB-1:0] strb_q, strb_d;
    logic [3:0]          reg_in_q, reg_in_d;
    logic                reg_ir_q, reg_ir_d;
    logic                reg_il_q, reg_il_d;
    logic                done_a_q, done_a_d;
    logic                done_b_q, done_b_d;
    logic                busy_q, busy_d;

    logic                any_req;
    logic                grant_b;
    logic                exec_d;
    logic [2:0]          win_op;
    logic [3:0]          win_data;

`ifndef REG_ARB_FIXED_PRIO_EN
    // High when B should win a tie, i.e. A was served most recently.
    logic                prio_b_q, prio_b_d;
`endif

    // Winner selection; only meaningful while in IDLE.
    always_comb begin
        any_req = req_a | req_b;
`ifdef REG_ARB_FIXED_PRIO_EN
        grant_b = req_b & ~req_a;
`else
        grant_b = req_b & (~req_a | prio_b_q);
`endif
        win_op   = grant_b ? op_b   : op_a;
        win_data = grant_b ? data_b : data_a;
    end

    // Next-state logic: grant in IDLE, count down shift cycles in EXEC,
    // single-cycle DONE that hands priority to the other requester.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
`ifndef REG_ARB_FIXED_PRIO_EN
        prio_b_d = prio_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = EXEC;
                    owner_d = grant_b;
                    op_d    = win_op;
                    data_d  = win_data;
                    // Shift operand holds (count - 1); other ops take one cycle.
                    if (win_op == OP_SHR || win_op == OP_SHL) begin
                        cnt_d = win_data[1:0];
                    end else begin
                        cnt_d = 2'd0;
                    end
                end
            end
            EXEC: begin
                // Counter stops at zero; it never wraps back to 3.
                if (cnt_q == 2'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifndef REG_ARB_FIXED_PRIO_EN
                prio_b_d = ~owner_q;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign exec_d = (state_d == EXEC);

    // One strobe per opcode; strobe gi belongs to opcode gi+1.
    generate
        for (genvar gi = 0; gi < NUM_STRB; gi++) begin : g_strb
            assign strb_d[gi] = exec_d && (op_d == 3'(gi + 1));
        end
    endgenerate

    // Data-carrying outputs are forced to zero unless their strobe is active.
    always_comb begin
        reg_in_d = (exec_d && op_d == OP_LD)  ? data_d    : 4'd0;
        reg_ir_d = (exec_d && op_d == OP_SHR) ? data_d[3] : 1'b0;
        reg_il_d = (exec_d && op_d == OP_SHL) ? data_d[3] : 1'b0;
        done_a_d = (state_d == DONE) && !owner_d;
        done_b_d = (state_d == DONE) &&  owner_d;
        busy_d   = (state_d != IDLE);
    end

    // Control state; asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'd0;
            data_q   <= 4'd0;
            cnt_q    <= 2'd0;
            owner_q  <= 1'b0;
`ifndef REG_ARB_FIXED_PRIO_EN
            prio_b_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
`ifndef REG_ARB_FIXED_PRIO_EN
            prio_b_q <= prio_b_d;
`endif
        end
    end

    // Output registers, cleared together with the control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q   <= '0;
            reg_in_q <= 4'd0;
            reg_ir_q <= 1'b0;
            reg_il_q <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            strb_q   <= strb_d;
            reg_in_q <= reg_in_d;
            reg_ir_q <= reg_ir_d;
            reg_il_q <= reg_il_d;
            done_a_q <= done_a_d;
            done_b_q <= done_b_d;
            busy_q   <= busy_d;
        end
    end

    assign reg_cl  = strb_q[0];
    assign reg_ld  = strb_q[1];
    assign reg_inc = strb_q[2];
    assign reg_dec = strb_q[3];
    assign reg_sr  = strb_q[4];
    assign reg_sl  = strb_q[5];
    assign reg_in  = reg_in_q;
    assign reg_ir  = reg_ir_q;
    assign reg_il  = reg_il_q;
    assign done_a  = done_a_q;
    assign done_b  = done_b_q;
    assign busy    = busy_q;
    assign owner   = owner_q;

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_a, req_b  input  1  requester A/B operation request, held high until done.
REQ-005 op_a, op_b  input  3  opcode: 0 NOP, 1 CLR, 2 LD, 3 INC, 4 DEC, 5 SHR, 6 SHL, 7 NOP.
REQ-006 data_a, data_b  input  4  LD value; for SHR/SHL: [1:0]=shift count-1, [3]=fill bit.
REQ-007 done_a, done_b  output  1  one-cycle completion pulse to the owning requester.
REQ-008 reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl  output  1  shared 4-bit register control strobes.
REQ-009 reg_ir, reg_il  output  1  serial fill bit for right/left shift.
REQ-010 reg_in  output  4  load value to shared register.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 owner  output  1  current or last grantee, 0=A, 1=B.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DONE; all outputs registered.
REQ-014 IDLE with any req high SHALL select a winner, latch its op/data, set owner, go EXEC next cycle.
REQ-015 Simultaneous req_a and req_b SHALL grant the requester not served last (round-robin pointer).
REQ-016 Single request SHALL be granted immediately regardless of pointer.
REQ-017 EXEC SHALL assert exactly one strobe matching the latched op (CLR->reg_cl, LD->reg_ld with reg_in=data, INC->reg_inc, DEC->reg_dec, SHR->reg_sr, SHL->reg_sl); NOP asserts none.
REQ-018 CLR/LD/INC/DEC/NOP SHALL occupy EXEC for 1 cycle.
REQ-019 SHR/SHL SHALL occupy EXEC for data[1:0]+1 cycles (1..4), strobe high every EXEC cycle, reg_ir/reg_il = data[3] throughout.
REQ-020 At most one of reg_cl/ld/inc/dec/sr/sl SHALL be high in any cycle; reg_in, reg_ir, reg_il SHALL be 0 when unused.
REQ-021 DONE SHALL last 1 cycle, pulse done of owner only, update pointer to owner, return to IDLE.
REQ-022 Latency: req sampled in IDLE cycle T -> strobe cycles T+1..T+k -> done at T+k+1 -> IDLE at T+k+2.
REQ-023 A requester whose req is still high in IDLE after its done SHALL be treated as a new request.
REQ-024 Changes on req/op/data during EXEC/DONE SHALL be ignored; the latched operation completes and done still pulses.
REQ-025 Shift counter SHALL never wrap: count 3 yields exactly 4 strobe cycles.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, all strobes/reg_in/reg_ir/reg_il/done/busy to 0, owner 0, pointer favouring A.
REQ-027 Reset mid-EXEC SHALL abort the operation with no done pulse; remaining shift cycles are discarded.

Configuration
REQ-028 Macro REG_ARB_FIXED_PRIO_EN defined: simultaneous requests always grant A; pointer unused.
REQ-029 Macro REG_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.

Verification
REQ-030 req_a, op_a=2, data_a=4'hA -> reg_ld=1, reg_in=4'hA one cycle later, done_a 2 cycles after sample.
REQ-031 req_a, op_a=5, data_a=4'b1011 -> reg_sr high 4 consecutive cycles, reg_ir=1, then done_a, busy low after.
REQ-032 req_a and req_b held with INC, no macro -> grants alternate A,B,A,B; owner toggles; done_a/done_b alternate.
REQ-033 Same as REQ-032 with REG_ARB_FIXED_PRIO_EN -> A granted every time, done_b never pulses.
REQ-034 rst_n low in 2nd cycle of SHL count 3 -> all strobes 0 immediately, no done_a, IDLE after release.
REQ-035 op_b=0 (NOP) -> no strobe asserted, done_b pulses 2 cycles after sample.
